// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read/clear bus of the multi-port register file
// master drives clear request, write ports and read ports; slave returns read data and status
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic                       clr_req;
    logic                       init_busy;
    logic [NUM_WR-1:0]          we;
    logic [NUM_WR*ADDR_W-1:0]   waddr;
    logic [NUM_WR*DATA_W-1:0]   wdata;
    logic [NUM_RD-1:0]          re;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       wr_collision;

    modport master (
        output clr_req, we, waddr, wdata, re, raddr,
        input  init_busy, rdata, wr_collision
    );

    modport slave (
        input  clr_req, we, waddr, wdata, re, raddr,
        output init_busy, rdata, wr_collision
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with hardware clear and write-collision flag
// clk, rst_n (async active-low); rf.slave carries clr_req/init_busy, write ports (we/waddr/wdata),
// read ports (re/raddr/rdata, combinational with write bypass) and the registered wr_collision pulse
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  rf
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                coll_q, coll_d;
    logic [NUM_WR-1:0]   wr_ok;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // a write only counts (for storage and collision) when it would actually commit
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NUM_WR; k++)
            wr_ok[k] = rf.we[k] && state_q == IDLE &&
                       !(ZERO_REG != 0 && rf.waddr[k*ADDR_W +: ADDR_W] == '0);
    end

    always_comb begin
        coll_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (wr_ok[i] && wr_ok[j] &&
                    rf.waddr[i*ADDR_W +: ADDR_W] == rf.waddr[j*ADDR_W +: ADDR_W])
                    coll_d = 1'b1;
    end

    // clear counter wraps to 0 exactly as the last entry is written, leaving it ready for the next clear
    always_comb begin
        state_d   = state_q == CLEAR ? (&clr_cnt_q ? IDLE : CLEAR) : (rf.clr_req ? CLEAR : IDLE);
        clr_cnt_d = state_q == CLEAR ? clr_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            coll_q    <= coll_d;
        end
    end

    // storage has no reset so it stays RAM-inferable; ascending loop lets the higher port win
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem_q[clr_cnt_q] <= '0;
        else
            for (int k = 0; k < NUM_WR; k++)
                if (wr_ok[k])
                    mem_q[rf.waddr[k*ADDR_W +: ADDR_W]] <= rf.wdata[k*DATA_W +: DATA_W];
    end

    always_comb begin
        rf.rdata = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rf.rdata[j*DATA_W +: DATA_W] = mem_q[rf.raddr[j*ADDR_W +: ADDR_W]];
            for (int k = 0; k < NUM_WR; k++)
                if (rf.we[k] && rf.waddr[k*ADDR_W +: ADDR_W] == rf.raddr[j*ADDR_W +: ADDR_W])
                    rf.rdata[j*DATA_W +: DATA_W] = rf.wdata[k*DATA_W +: DATA_W];
            if (state_q == CLEAR || !rf.re[j] ||
                (ZERO_REG != 0 && rf.raddr[j*ADDR_W +: ADDR_W] == '0))
                rf.rdata[j*DATA_W +: DATA_W] = '0;
        end
    end

    assign rf.init_busy    = state_q == CLEAR;
    assign rf.wr_collision = coll_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (2-write/ZERO_REG=1 and 1-write/ZERO_REG=0 instances)
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    regfile_mp_if #(.NUM_WR(2)) ia ();
    regfile_mp_if #(.NUM_WR(1)) ib ();

    regfile_mp #(.NUM_WR(2), .ZERO_REG(1)) u_a (.clk(clk), .rst_n(rst_n), .rf(ia.slave));
    regfile_mp #(.NUM_WR(1), .ZERO_REG(0)) u_b (.clk(clk), .rst_n(rst_n), .rf(ib.slave));

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];

    // sources: 0/1 = A read ports, 2 = B read port 0, 3 = A init_busy, 4 = A wr_collision
    function automatic logic [31:0] obs(input int src);
        case (src)
            0:       return ia.rdata[31:0];
            1:       return ia.rdata[63:32];
            2:       return ib.rdata[31:0];
            3:       return {31'd0, ia.init_busy};
            default: return {31'd0, ia.wr_collision};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int src, input logic [31:0] exp);
        sb_t it;
        it.tag = tag;
        it.src = src;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic drain();
        sb_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.tag, obs(it.src), it.exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    // counts busy cycles; injects a write to r3 and a clr_req mid-clear, both of which must be ignored
    task automatic wait_busy(output int cnt);
        cnt = 0;
        repeat (100) begin
            ia.we = 2'b00;
            ia.clr_req = 1'b0;
            if (cnt == 10) begin
                ia.we = 2'b01;
                ia.waddr = {5'd0, 5'd3};
                ia.wdata = {32'h0, 32'hFFFF_FFFF};
            end
            if (cnt == 12) ia.clr_req = 1'b1;
            ia.re = 2'b11;
            ia.raddr = {5'd20, 5'd3};
            @(negedge clk);
            if (!ia.init_busy) break;
            push("busy_rd0", 0, 32'h0);
            push("busy_rd1", 1, 32'h0);
            drain();
            cnt++;
            @(posedge clk);
            #1;
        end
        ia.we = 2'b00;
        ia.clr_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.clr_req = 1'b0; ia.we = '0; ia.waddr = '0; ia.wdata = '0; ia.re = '0; ia.raddr = '0;
        ib.clr_req = 1'b0; ib.we = '0; ib.waddr = '0; ib.wdata = '0; ib.re = '0; ib.raddr = '0;
        @(posedge clk);
        #1;
        push("rst_busy", 3, 32'd1);
        push("rst_coll", 4, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_busy(n);
        check("init_cycles", n, 32);

        ia.re = 2'b11; ia.raddr = {5'd31, 5'd7};
        ib.re = 2'b01; ib.raddr = {5'd0, 5'd7};
        push("idle_busy", 3, 32'd0);
        push("init_r7", 0, 32'h0);
        push("init_r31", 1, 32'h0);
        push("b_init_r7", 2, 32'h0);
        step();

        ia.we = 2'b01; ia.waddr = {5'd0, 5'd5}; ia.wdata = {32'h0, 32'hDEAD_BEEF};
        ia.raddr = {5'd5, 5'd7};
        push("bypass_r5", 1, 32'hDEAD_BEEF);
        push("other_r7", 0, 32'h0);
        step();
        ia.we = 2'b00;
        push("stored_r5", 1, 32'hDEAD_BEEF);
        step();
        ia.re = 2'b01;
        push("re_off", 1, 32'h0);
        step();
        ia.re = 2'b11;

        ia.we = 2'b01; ia.waddr = '0; ia.wdata = {32'h0, 32'h1234_5678};
        ia.raddr = '0;
        ib.we = 1'b1; ib.waddr = '0; ib.wdata = 32'h1234_5678; ib.raddr = '0;
        push("zr_byp0", 0, 32'h0);
        push("zr_byp1", 1, 32'h0);
        push("nz_byp_r0", 2, 32'h1234_5678);
        step();
        ia.we = 2'b00; ib.we = 1'b0;
        push("zr_rd0", 0, 32'h0);
        push("zr_rd1", 1, 32'h0);
        push("nz_rd_r0", 2, 32'h1234_5678);
        step();

        ia.we = 2'b11; ia.waddr = {5'd9, 5'd9}; ia.wdata = {32'h2222, 32'h1111};
        ia.raddr = {5'd9, 5'd9};
        push("coll_byp", 0, 32'h2222);
        push("coll_pre", 4, 32'd0);
        step();
        ia.we = 2'b00;
        push("coll_rd", 0, 32'h2222);
        push("coll_flag", 4, 32'd1);
        step();
        push("coll_clr", 4, 32'd0);
        step();
        ia.we = 2'b11; ia.waddr = {5'd11, 5'd10}; ia.wdata = {32'hBBBB, 32'hAAAA};
        step();
        ia.we = 2'b00; ia.raddr = {5'd11, 5'd10};
        push("dual_r10", 0, 32'hAAAA);
        push("dual_r11", 1, 32'hBBBB);
        push("dual_nocoll", 4, 32'd0);
        step();
        ia.we = 2'b11; ia.waddr = '0; ia.wdata = {32'h5, 32'h6};
        step();
        ia.we = 2'b00;
        push("r0_nocoll", 4, 32'd0);
        step();

        for (int i = 1; i < 32; i++) begin
            ia.we = 2'b10;
            ia.waddr = {5'(i), 5'd0};
            ia.wdata = {32'hA500_0000 | 32'(i), 32'h0};
            ia.raddr = {5'(i - 1), 5'(i)};
            push("fill_byp", 0, 32'hA500_0000 | 32'(i));
            push("fill_prev", 1, i == 1 ? 32'h0 : 32'hA500_0000 | 32'(i - 1));
            step();
        end
        ia.we = 2'b00;
        ia.clr_req = 1'b1;
        push("clr_pre_busy", 3, 32'd0);
        step();
        ia.clr_req = 1'b0;
        wait_busy(n);
        check("clr_cycles", n, 32);
        for (int i = 0; i < 16; i++) begin
            ia.raddr = {5'(2 * i + 1), 5'(2 * i)};
            push("cleared_even", 0, 32'h0);
            push("cleared_odd", 1, 32'h0);
            step();
        end

        ia.we = 2'b01; ia.waddr = {5'd0, 5'd20}; ia.wdata = {32'h0, 32'h2020_2020};
        step();
        ia.we = 2'b00; ia.raddr = {5'd0, 5'd20};
        push("r20_set", 0, 32'h2020_2020);
        step();
        ia.clr_req = 1'b1;
        step();
        ia.clr_req = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        push("midrst_busy", 3, 32'd1);
        push("midrst_coll", 4, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_busy(n);
        check("rerun_cycles", n, 32);
        ia.re = 2'b11; ia.raddr = {5'd20, 5'd20};
        push("r20_clr0", 0, 32'h0);
        push("r20_clr1", 1, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
